alu_ctrl_muldiv: RTL and testbench

ALU control decoder for the EX stage of the 5-stage forwarding pipeline, extended with an iterative multiply/divide engine and the HI/LO register pair. Ordinary ALU decode is unchanged: R-type funct decode, otherwise ALUop pass-through. The block adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, with a `stall` output to hazard control. It sits between the ID/EX register and the ALU and result mux, and is parametrised in datapath width.

---
 rtl/alu_ctrl_muldiv_pkg.sv | 54 +++++
 rtl/alu_ctrl_muldiv_md_iter.sv | 121 ++++++++++++
 rtl/alu_ctrl_muldiv.sv | 123 ++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the HI/LO multiply/divide unit.
// Holds ALU control codes, funct values, the R-type ALUop and the engine state type.
package alu_pkg;

  localparam logic [3:0] RTYPE_OP_DEF = 4'b1111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_md_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring shift-subtract step per cycle.
// Operands latched on start; WIDTH steps while run is high; sign-fixed results are combinational.
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             run,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic             neg_main_q, neg_main_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, diff, sum;
  logic             qbit;

  always_comb begin
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    div_d      = div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;

    a_neg   = is_signed & op_a[WIDTH-1];
    b_neg   = is_signed & op_b[WIDTH-1];
    a_mag   = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag   = b_neg ? (~op_b + 1'b1) : op_b;

    // acc_hi holds the partial product / remainder, acc_lo the multiplier / quotient
    r_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff    = r_shift - {1'b0, opb_q};
    qbit    = ~diff[WIDTH];
    sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    if (start) begin
      cnt_d      = CW'(WIDTH);
      acc_hi_d   = '0;
      acc_lo_d   = a_mag;
      opb_d      = b_mag;
      div_d      = is_div;
      neg_main_d = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      div0_d     = is_div && (op_b == '0);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        acc_hi_d = qbit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], qbit};
      end else begin
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_main_q ? (~prod + 1'b1) : prod;
    if (div_q) begin
      // With a zero divisor the remainder path has shifted |rs| through, so its sign fix restores rs
      res_hi = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
      if (div0_q)
        res_lo = '1;
      else
        res_lo = neg_main_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      div_q      <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      div_q      <= div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decode plus HI/LO registers and the multiply/divide start/stall handshake.
// Decode and MF reads are combinational; HI/LO-group instructions stall while the engine is not IDLE.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int                 WIDTH    = 32,
  parameter int                 ALUOP_W  = 4,
  parameter logic [ALUOP_W-1:0] RTYPE_OP = ALUOP_W'(RTYPE_OP_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic               ex_valid,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic               mf_sel,
  output logic [WIDTH-1:0]   mf_data,
  output logic               stall,
  output logic               md_busy
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             hilo_grp;
  logic             md_start, md_last, md_is_div, md_signed;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [3:0]       r_code;

  always_comb begin
    r_code = ALU_AND;
    case (funct)
      F_SLL:   r_code = ALU_SLL;
      F_SRL:   r_code = ALU_SRL;
      F_SRA:   r_code = ALU_SRA;
      F_ADD:   r_code = ALU_ADD;
      F_ADDU:  r_code = ALU_ADDU;
      F_SUB:   r_code = ALU_SUB;
      F_SUBU:  r_code = ALU_SUBU;
      F_AND:   r_code = ALU_AND;
      F_OR:    r_code = ALU_OR;
      F_XOR:   r_code = ALU_XOR;
      F_NOR:   r_code = ALU_NOR;
      F_SLT:   r_code = ALU_SLT;
      F_SLTU:  r_code = ALU_SLTU;
      default: r_code = ALU_AND;
    endcase
  end

  assign alu_ctrl  = (alu_op != RTYPE_OP) ? alu_op : ALUOP_W'(r_code);
  assign hilo_grp  = ex_valid && (alu_op == RTYPE_OP) && is_hilo_funct(funct);
  assign md_is_div = (funct == F_DIV) || (funct == F_DIVU);
  assign md_signed = (funct == F_MULT) || (funct == F_DIV);
  assign mf_data   = (funct == F_MFHI) ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mf_sel   = 1'b0;
    md_start = 1'b0;
    md_busy  = (state_q != IDLE);
    // Only HI/LO-group work waits on the engine; everything else keeps flowing
    stall    = hilo_grp && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (hilo_grp) begin
          case (funct)
            F_MFHI, F_MFLO: mf_sel = 1'b1;
            F_MTHI:         hi_d   = rs_val;
            F_MTLO:         lo_d   = rs_val;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              md_start = 1'b1;
              state_d  = BUSY;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (md_last) state_d = FIX;
      end
      FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  md_iter #(
    .WIDTH(WIDTH)
  ) u_md_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .is_div   (md_is_div),
    .is_signed(md_signed),
    .op_a     (rs_val),
    .op_b     (rt_val),
    .run      (state_q == BUSY),
    .last     (md_last),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomised and directed check of alu_ctrl_muldiv against an arithmetic reference model.
module tb_alu_ctrl_muldiv;

  localparam int W = 32;
  localparam logic [3:0] RT = 4'b1111;

  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    alu_op = '0;
  logic [5:0]    funct = '0;
  logic          ex_valid = 1'b0;
  logic [W-1:0]  rs_val = '0, rt_val = '0;
  logic [3:0]    alu_ctrl;
  logic          mf_sel, stall, md_busy;
  logic [W-1:0]  mf_data;

  int total = 0;
  int bad = 0;
  int dec_tbl[int];

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(W), .ALUOP_W(4), .RTYPE_OP(RT)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .ex_valid(ex_valid),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctrl(alu_ctrl), .mf_sel(mf_sel),
    .mf_data(mf_data), .stall(stall), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; funct = f; ex_valid = v; rs_val = a; rt_val = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_ctrl(input logic [3:0] op, input logic [5:0] f);
    if (op != RT) return op;
    if (dec_tbl.exists(int'(f))) return 4'(dec_tbl[int'(f)]);
    return 4'b0000;
  endfunction

  function automatic logic in_grp(input logic [5:0] f);
    return f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  // Reference: the architectural result of each operation, from plain integer arithmetic
  task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    int sa, sb;
    longint sp;
    logic [63:0] up;
    sa = a; sb = b;
    h = '0; l = '0;
    case (f)
      MULT:  begin sp = longint'(sa) * longint'(sb); {h, l} = sp; end
      MULTU: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      DIV: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = '0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      default: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  // Inputs are already driven; counts cycles with stall high, bounded
  task automatic count_stall(input string tag, input int exp_n);
    int n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      tick;
      #1;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    drive(RT, MFLO, 1'b1, '0, '0);
    #1;
    chk({tag, "_lo_sel"}, mf_sel, 1'b1);
    chk({tag, "_lo"}, mf_data, el);
    tick;
    drive(RT, MFHI, 1'b1, '0, '0);
    #1;
    chk({tag, "_hi"}, mf_data, eh);
    chk({tag, "_hi_stall"}, stall, 1'b0);
    tick;
  endtask

  task automatic issue_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    drive(RT, f, 1'b1, a, b);
    #1;
    chk({tag, "_start_stall"}, stall, 1'b0);
    chk({tag, "_start_busy"}, md_busy, 1'b0);
    tick;
  endtask

  task automatic run_case(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    issue_md(tag, f, a, b);
    drive(RT, MFLO, 1'b1, '0, '0);
    count_stall({tag, "_stall_len"}, W + 1);
    read_hilo(tag, eh, el);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] eh, el, a, b;
    logic [5:0]   f;
    logic [3:0]   op;
    logic [5:0]   md_ops[4];

    dec_tbl[6'b000000] = 4'b0011; dec_tbl[6'b000010] = 4'b0100; dec_tbl[6'b000011] = 4'b1101;
    dec_tbl[6'b100000] = 4'b0010; dec_tbl[6'b100001] = 4'b1000; dec_tbl[6'b100010] = 4'b0110;
    dec_tbl[6'b100011] = 4'b1001; dec_tbl[6'b100100] = 4'b0000; dec_tbl[6'b100101] = 4'b0001;
    dec_tbl[6'b100110] = 4'b1010; dec_tbl[6'b100111] = 4'b1100; dec_tbl[6'b101010] = 4'b0111;
    dec_tbl[6'b101011] = 4'b1011;
    md_ops[0] = MULT; md_ops[1] = MULTU; md_ops[2] = DIV; md_ops[3] = DIVU;

    // Reset state
    drive(RT, MFLO, 1'b1, '0, '0);
    #3;
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mf_sel", mf_sel, 1'b1);
    chk("rst_lo", mf_data, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;

    // Directed decode
    drive(RT, SUB, 1'b1, '0, '0); #1;
    chk("dec_sub", alu_ctrl, 4'b0110);
    drive(4'b0010, SUB, 1'b1, '0, '0); #1;
    chk("dec_pass", alu_ctrl, 4'b0010);
    drive(RT, 6'b111111, 1'b1, '0, '0); #1;
    chk("dec_unknown", alu_ctrl, 4'b0000);
    chk("dec_unknown_stall", stall, 1'b0);
    drive(RT, MFHI, 1'b0, '0, '0); #1;
    chk("mf_bubble_sel", mf_sel, 1'b0);
    tick;

    // Random decode on non-HI/LO traffic
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 1) ? RT : 4'($urandom_range(0, 15));
      f  = 6'($urandom_range(0, 63));
      drive(op, f, (op == RT && in_grp(f)) ? 1'b0 : 1'($urandom_range(0, 1)), $urandom, $urandom);
      #1;
      chk("rnd_dec", alu_ctrl, exp_ctrl(op, f));
      chk("rnd_dec_stall", stall, 1'b0);
      chk("rnd_dec_mf", mf_sel, 1'b0);
      tick;
    end

    // Directed multiply/divide
    run_case("mult", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_case("divu", DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    run_case("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_case("div0", DIV, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    run_case("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MFHI next cycle
    drive(RT, MTHI, 1'b1, 32'h00001234, '0); #1;
    chk("mthi_stall", stall, 1'b0);
    tick;
    drive(RT, MFHI, 1'b1, '0, '0); #1;
    chk("mfhi_after_mthi", mf_data, 32'h00001234);
    chk("mfhi_after_mthi_stall", stall, 1'b0);
    tick;

    // MTLO issued while busy must wait, then overwrite LO after FIX
    a = $urandom; b = $urandom;
    ref_md(MULT, a, b, eh, el);
    issue_md("mtlo_ovl", MULT, a, b);
    drive(RT, MTLO, 1'b1, 32'hCAFEF00D, '0);
    count_stall("mtlo_ovl_stall_len", W + 1);
    tick;
    read_hilo("mtlo_ovl", eh, 32'hCAFEF00D);

    // ALU traffic flows during BUSY
    a = $urandom; b = $urandom;
    ref_md(MULTU, a, b, eh, el);
    issue_md("add_ovl", MULTU, a, b);
    drive(RT, ADD, 1'b1, $urandom, $urandom); #1;
    chk("add_ovl_stall", stall, 1'b0);
    chk("add_ovl_ctrl", alu_ctrl, 4'b0010);
    chk("add_ovl_busy", md_busy, 1'b1);
    chk("add_ovl_mf", mf_sel, 1'b0);
    tick;
    drive(RT, MFLO, 1'b1, '0, '0);
    count_stall("add_ovl_stall_len", W);
    read_hilo("add_ovl", eh, el);

    // Reset in the middle of BUSY
    issue_md("rst_mid", MULT, $urandom, $urandom);
    drive(RT, MFLO, 1'b1, '0, '0);
    repeat (9) tick;
    #1;
    chk("rst_mid_pre_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_busy", md_busy, 1'b0);
    chk("rst_mid_lo", mf_data, '0);
    drive(RT, MFHI, 1'b1, '0, '0); #1;
    chk("rst_mid_hi", mf_data, '0);
    rst_n = 1'b1;
    tick;
    run_case("post_rst", MULT, 32'd3, 32'd4, 32'h00000000, 32'h0000000C);

    // Randomised multiply/divide against the model
    for (int i = 0; i < 16; i++) begin
      f = md_ops[$urandom_range(0, 3)];
      a = pick_operand();
      b = pick_operand();
      ref_md(f, a, b, eh, el);
      run_case("rnd_md", f, a, b, eh, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
